// File: rtl/rsa_exp_sequencer.sv
// RSA modular exponentiation sequencer: right-to-left binary method.
// Drives one prep engine and one shared Montgomery engine.
module rsa_exp_sequencer #(
    parameter int WIDTH = 256,
    parameter int CNT_W = 9
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_d,
    input  logic [WIDTH-1:0] i_n,
    output logic             o_busy,
    output logic             o_finished,
    output logic [WIDTH-1:0] o_result,
    output logic             o_prep_start,
    output logic [WIDTH-1:0] o_prep_y,
    input  logic             i_prep_done,
    input  logic [WIDTH-1:0] i_prep_t,
    output logic             o_mont_start,
    output logic [WIDTH-1:0] o_mont_a,
    output logic [WIDTH-1:0] o_mont_b,
    output logic [WIDTH-1:0] o_mont_n,
    input  logic             i_mont_done,
    input  logic [WIDTH-1:0] i_mont_r
);

    typedef enum logic [3:0] {
        IDLE,
        PREP_GO,
        PREP_WAIT,
        MUL_GO,
        MUL_WAIT,
        SQR_GO,
        SQR_WAIT,
        NEXT,
        DONE
    } state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] y_r;
    logic [WIDTH-1:0] d_r;
    logic [WIDTH-1:0] n_r;
    logic [WIDTH-1:0] t_r;
    logic [WIDTH-1:0] m_r;
    logic [WIDTH-1:0] result_r;
    logic [CNT_W-1:0] cnt;

    // d_r shifts right once per bit so the current bit is always d_r[0]
    // and the next one is d_r[1]; avoids a wide variable bit-select.

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Operand, accumulator and result registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            y_r      <= '0;
            d_r      <= '0;
            n_r      <= '0;
            t_r      <= '0;
            m_r      <= '0;
            result_r <= '0;
            cnt      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_start) begin
                        y_r <= i_a;
                        d_r <= i_d;
                        n_r <= i_n;
                        m_r <= WIDTH'(1);
                        cnt <= '0;
                    end
                end
                PREP_WAIT: begin
                    if (i_prep_done) begin
                        t_r <= i_prep_t;
                    end
                end
                MUL_WAIT: begin
                    if (i_mont_done) begin
                        m_r <= i_mont_r;
                    end
                end
                SQR_WAIT: begin
                    if (i_mont_done) begin
                        t_r <= i_mont_r;
                    end
                end
                NEXT: begin
                    if (cnt == LAST) begin
                        result_r <= m_r;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                        d_r <= d_r >> 1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Next-state decode and engine handshake outputs.
    always_comb begin
        state_nxt    = state;
        o_prep_start = 1'b0;
        o_mont_start = 1'b0;
        o_mont_a     = '0;
        o_mont_b     = '0;
        o_finished   = 1'b0;
        unique case (state)
            IDLE: begin
                if (i_start) state_nxt = PREP_GO;
            end
            PREP_GO: begin
                o_prep_start = 1'b1;
                state_nxt    = PREP_WAIT;
            end
            PREP_WAIT: begin
                if (i_prep_done) state_nxt = d_r[0] ? MUL_GO : SQR_GO;
            end
            MUL_GO: begin
                o_mont_start = 1'b1;
                o_mont_a     = m_r;
                o_mont_b     = t_r;
                state_nxt    = MUL_WAIT;
            end
            MUL_WAIT: begin
                o_mont_a = m_r;
                o_mont_b = t_r;
                if (i_mont_done) state_nxt = SQR_GO;
            end
            SQR_GO: begin
                o_mont_start = 1'b1;
                o_mont_a     = t_r;
                o_mont_b     = t_r;
                state_nxt    = SQR_WAIT;
            end
            SQR_WAIT: begin
                o_mont_a = t_r;
                o_mont_b = t_r;
                if (i_mont_done) state_nxt = NEXT;
            end
            NEXT: begin
                if (cnt == LAST) state_nxt = DONE;
                else state_nxt = d_r[1] ? MUL_GO : SQR_GO;
            end
            DONE: begin
                o_finished = 1'b1;
                state_nxt  = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign o_busy   = (state != IDLE);
    assign o_result = result_r;
    assign o_prep_y = y_r;
    assign o_mont_n = n_r;

endmodule
